// File: rtl/demo_arb.sv
// ============================================================================
//  Module      : demo_arb
//  Description : Round-robin / fixed-priority arbiter and sequencer sharing a
//                single demo logic unit among NREQ requesters. Grants one
//                requester, issues a start pulse, waits for done (with a
//                timeout) and returns the result with a one-cycle ack.
//  Config      : DEMO_ARB_RR_EN defined   -> round-robin selection
//                DEMO_ARB_RR_EN undefined -> fixed priority (lowest index wins)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module demo_arb #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  input  logic [NREQ*3-1:0]    req_op,
  output logic [NREQ-1:0]      ack,
  output logic [31:0]          rsp_y,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 alu_start,
  output logic [31:0]          alu_a,
  output logic [31:0]          alu_b,
  output logic [2:0]           alu_op,
  input  logic                 alu_done,
  input  logic [31:0]          alu_y
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // Current state and registered outputs
  state_t            r_state;
  logic [IW-1:0]     r_gnt;     // grant index; doubles as the round-robin pointer
  logic [7:0]        r_cnt;
  logic [NREQ-1:0]   r_ack;
  logic [31:0]       r_rsp_y;
  logic              r_rsp_err;
  logic              r_busy;
  logic              r_start;
  logic [31:0]       r_a;
  logic [31:0]       r_b;
  logic [2:0]        r_op;

  // Next-state values
  state_t            w_state_n;
  logic [IW-1:0]     w_gnt_n;
  logic [7:0]        w_cnt_n;
  logic [NREQ-1:0]   w_ack_n;
  logic [31:0]       w_rsp_y_n;
  logic              w_rsp_err_n;
  logic              w_start_n;
  logic [31:0]       w_a_n;
  logic [31:0]       w_b_n;
  logic [2:0]        w_op_n;
  logic [IW-1:0]     w_win;
  logic [NREQ-1:0]   w_onehot;

`ifdef DEMO_ARB_RR_EN
  // Index k positions after the pointer, wrapping modulo NREQ
  function automatic logic [IW-1:0] f_rr_idx(input logic [IW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return IW'(s);
  endfunction

  // Round-robin winner: first set request after the last grant; descending
  // scan so the nearest candidate is written last
  always_comb begin
    w_win = r_gnt;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[f_rr_idx(r_gnt, k)]) w_win = f_rr_idx(r_gnt, k);
    end
  end
`else
  // Fixed-priority winner: lowest set request index
  always_comb begin
    w_win = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) w_win = IW'(i);
    end
  end
`endif

  // One-hot decode of the current grant for the ack pulse
  always_comb begin
    w_onehot        = '0;
    w_onehot[r_gnt] = 1'b1;
  end

  // Next-state and next-output logic; outputs are registered from these
  always_comb begin
    w_state_n   = r_state;
    w_gnt_n     = r_gnt;
    w_cnt_n     = r_cnt;
    w_ack_n     = '0;
    w_rsp_y_n   = r_rsp_y;
    w_rsp_err_n = r_rsp_err;
    w_start_n   = 1'b0;
    w_a_n       = r_a;
    w_b_n       = r_b;
    w_op_n      = r_op;
    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_gnt_n   = w_win;
          w_a_n     = req_a[32*int'(w_win) +: 32];
          w_b_n     = req_b[32*int'(w_win) +: 32];
          w_op_n    = req_op[3*int'(w_win) +: 3];
          w_start_n = 1'b1;
          w_state_n = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_cnt_n   = '0;
        w_state_n = S_WAIT;
      end
      S_WAIT: begin
        if (alu_done) begin
          w_rsp_y_n   = alu_y;
          w_rsp_err_n = 1'b0;
          w_ack_n     = w_onehot;
          w_state_n   = S_RESP;
        end else if (r_cnt == 8'(TIMEOUT - 1)) begin
          w_rsp_y_n   = '0;
          w_rsp_err_n = 1'b1;
          w_ack_n     = w_onehot;
          w_state_n   = S_RESP;
        end else begin
          w_cnt_n = r_cnt + 8'd1;
        end
      end
      S_RESP: begin
        w_state_n = S_IDLE;
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
`ifdef DEMO_ARB_RR_EN
      r_gnt     <= IW'(NREQ - 1);
`else
      r_gnt     <= '0;
`endif
      r_cnt     <= '0;
      r_ack     <= '0;
      r_rsp_y   <= '0;
      r_rsp_err <= 1'b0;
      r_busy    <= 1'b0;
      r_start   <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= '0;
    end else begin
      r_state   <= w_state_n;
      r_gnt     <= w_gnt_n;
      r_cnt     <= w_cnt_n;
      r_ack     <= w_ack_n;
      r_rsp_y   <= w_rsp_y_n;
      r_rsp_err <= w_rsp_err_n;
      r_busy    <= (w_state_n != S_IDLE);
      r_start   <= w_start_n;
      r_a       <= w_a_n;
      r_b       <= w_b_n;
      r_op      <= w_op_n;
    end
  end

  assign ack       = r_ack;
  assign rsp_y     = r_rsp_y;
  assign rsp_err   = r_rsp_err;
  assign busy      = r_busy;
  assign alu_start = r_start;
  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign alu_op    = r_op;

endmodule

`default_nettype wire

// File: tb/tb_demo_arb.sv
// ============================================================================
//  Module      : tb_demo_arb
//  Description : Directed self-checking bench for demo_arb with a small
//                behavioural model of the shared demo logic unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demo_arb;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ*32-1:0]   req_a;
  logic [NREQ*32-1:0]   req_b;
  logic [NREQ*3-1:0]    req_op;
  logic [NREQ-1:0]      ack;
  logic [31:0]          rsp_y;
  logic                 rsp_err;
  logic                 busy;
  logic                 alu_start;
  logic [31:0]          alu_a;
  logic [31:0]          alu_b;
  logic [2:0]           alu_op;
  logic                 alu_done;
  logic [31:0]          alu_y;
  logic                 tie_done0;

  int nvec  = 0;
  int nfail = 0;

  demo_arb #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .ack       (ack),
    .rsp_y     (rsp_y),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .alu_start (alu_start),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_done  (alu_done),
    .alu_y     (alu_y)
  );

  always #5 clk = ~clk;

  // Behavioural demo unit: done and Y registered one edge after start
  always @(posedge clk) begin
    if (rst) begin
      alu_done <= 1'b0;
      alu_y    <= '0;
    end else begin
      alu_done <= alu_start & ~tie_done0;
      case (alu_op)
        3'd0:    alu_y <= alu_a & alu_b;
        3'd1:    alu_y <= alu_a | alu_b;
        3'd2:    alu_y <= ~alu_a;
        3'd3:    alu_y <= alu_a ^ alu_b;
        3'd4:    alu_y <= ~(alu_a ^ alu_b);
        default: alu_y <= '0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic set_slot(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_op[3*i +: 3]  = op;
  endtask

  logic [NREQ-1:0] fair_exp [5];

  initial begin
`ifdef DEMO_ARB_RR_EN
    fair_exp[0] = 4'b0001; fair_exp[1] = 4'b0010; fair_exp[2] = 4'b0100;
    fair_exp[3] = 4'b1000; fair_exp[4] = 4'b0001;
`else
    fair_exp[0] = 4'b0001; fair_exp[1] = 4'b0001; fair_exp[2] = 4'b0001;
    fair_exp[3] = 4'b0001; fair_exp[4] = 4'b0001;
`endif
    rst = 1'b1; req = '0; req_a = '0; req_b = '0; req_op = '0; tie_done0 = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_ack",   32'(ack), 32'h0);
    chk("rst_y",     rsp_y, 32'h0);
    chk("rst_err",   32'(rsp_err), 32'h0);
    chk("rst_busy",  32'(busy), 32'h0);
    chk("rst_start", 32'(alu_start), 32'h0);
    chk("rst_a",     alu_a, 32'h0);
    chk("rst_b",     alu_b, 32'h0);
    chk("rst_op",    32'(alu_op), 32'h0);
    rst = 1'b0;

    // Single request: AND on requester 0
    set_slot(0, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'd0);
    req = 4'b0001;
    tick();
    chk("s1_start",  32'(alu_start), 32'h1);
    chk("s1_busy",   32'(busy), 32'h1);
    chk("s1_a",      alu_a, 32'hF0F0_F0F0);
    chk("s1_b",      alu_b, 32'hFF00_FF00);
    tick();
    chk("s2_start",  32'(alu_start), 32'h0);
    chk("s2_ack",    32'(ack), 32'h0);
    tick();
    chk("s3_ack",    32'(ack), 32'h1);
    chk("s3_y",      rsp_y, 32'hF000_F000);
    chk("s3_err",    32'(rsp_err), 32'h0);
    chk("s3_busy",   32'(busy), 32'h1);
    req = '0;
    tick();
    chk("s4_ack",    32'(ack), 32'h0);
    chk("s4_busy",   32'(busy), 32'h0);

    // Fairness from a fresh pointer
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_slot(i, 32'(i), 32'h0, 3'd1);
    req = 4'b1111;
    tick(); tick(); tick();
    chk("fair0", 32'(ack), 32'(fair_exp[0]));
    for (int n = 1; n < 5; n++) begin
      tick(); tick(); tick(); tick();
      chk("fair", 32'(ack), 32'(fair_exp[n]));
    end
    req = '0;
    tick();

    // Back-to-back: requester 2 XOR, then requester 1 OR
    set_slot(2, 32'h1234_5678, 32'hFFFF_FFFF, 3'd3);
    set_slot(1, 32'h0000_0000, 32'hA5A5_A5A5, 3'd1);
    req = 4'b0100;
    tick();
    req = 4'b0110;
    tick(); tick();
    chk("bb_ack0", 32'(ack), 32'h4);
    chk("bb_y0",   rsp_y, 32'hEDCB_A987);
    req = 4'b0010;
    tick(); tick();
    chk("bb_op1",  32'(alu_op), 32'h1);
    tick(); tick();
    chk("bb_ack1", 32'(ack), 32'h2);
    chk("bb_y1",   rsp_y, 32'hA5A5_A5A5);
    req = '0;
    tick();

    // Timeout on requester 3
    tie_done0 = 1'b1;
    set_slot(3, 32'hDEAD_BEEF, 32'h0, 3'd0);
    req = 4'b1000;
    tick(); tick(); tick(); tick(); tick();
    chk("to5_ack",  32'(ack), 32'h0);
    chk("to5_busy", 32'(busy), 32'h1);
    tick();
    chk("to6_ack",  32'(ack), 32'h8);
    chk("to6_err",  32'(rsp_err), 32'h1);
    chk("to6_y",    rsp_y, 32'h0);
    req = '0; tie_done0 = 1'b0;
    tick();

    // Reset during WAIT, then pointer restart
    set_slot(1, 32'h1111_1111, 32'h2222_2222, 3'd4);
    req = 4'b0010;
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("rm_ack",   32'(ack), 32'h0);
    chk("rm_busy",  32'(busy), 32'h0);
    chk("rm_start", 32'(alu_start), 32'h0);
    chk("rm_a",     alu_a, 32'h0);
    chk("rm_op",    32'(alu_op), 32'h0);
    chk("rm_err",   32'(rsp_err), 32'h0);
    rst = 1'b0;
    set_slot(0, 32'h0F0F_0F0F, 32'h0000_FFFF, 3'd0);
    req = 4'b1001;
    tick();
    chk("rm_a0",    alu_a, 32'h0F0F_0F0F);
    tick(); tick();
    chk("rm_ack0",  32'(ack), 32'h1);
    chk("rm_y0",    rsp_y, 32'h0000_0F0F);
    req = '0;
    tick();

    // Early drop: requester 1 NOT, req released during WAIT
    set_slot(1, 32'h0000_FFFF, 32'h0, 3'd2);
    req = 4'b0010;
    tick(); tick();
    req = '0;
    tick();
    chk("ed_ack", 32'(ack), 32'h2);
    chk("ed_y",   rsp_y, 32'hFFFF_0000);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("ed_nostart", 32'(alu_start), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/demo_arb.md
# demo_arb

Round-robin arbiter and sequencer that shares one `demo` logic unit (AND/OR/NOT/XOR/XNOR on 32-bit operands) among NREQ requesters.
- Each requester presents operands and an opcode with a level request.
- The arbiter grants one requester, latches its operands and pulses the unit's `start`, then waits for `done`.
- It returns the result with a one-cycle acknowledge, or an error if the unit never answers.
- It sits between the Wishbone-side register banks and the single `demo` instance.

## Interface
- NREQ, 4, number of requesters (2..8)
- TIMEOUT, 16, WAIT-state cycles without `alu_done` before the operation is aborted (1..255)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester request level; held until the matching `ack`
- req_a  in  NREQ*32  operand A; slice i = bits [32*i+31:32*i]
- req_b  in  NREQ*32  operand B, same packing
- req_op  in  NREQ*3  opcode, slice i = bits [3*i+2:3*i]
- ack  out  NREQ  one-hot, one-cycle completion pulse to the granted requester
- rsp_y  out  32  result, valid while `ack` is high
- rsp_err  out  1  timeout flag, valid while `ack` is high
- busy  out  1  high in every state except IDLE
- alu_start  out  1  to `demo.start`
- alu_a, alu_b  out  32  to `demo.A`/`demo.B`
- alu_op  out  3  to `demo.op`
- alu_done  in  1  from `demo.done`
- alu_y  in  32  from `demo.Y`

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- IDLE: if any `req` bit is set, select the winner g and register `alu_a`, `alu_b` and `alu_op` from slice g. Go to ISSUE. Otherwise stay in IDLE.
- ISSUE: `alu_start` is 1 for exactly this cycle. Go to WAIT and clear the timeout counter.
- WAIT: `alu_start` is 0.
  - If `alu_done`=1, capture `alu_y` into `rsp_y`, set `rsp_err`=0 and go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 with no `done`, set `rsp_y`=0, `rsp_err`=1 and go to RESP.
- RESP: `ack[g]`=1 for one cycle. Go to IDLE.
- Winner selection (round-robin): pointer `last` holds the index of the most recent grant. The search starts at `last`+1 modulo NREQ. `last` updates to g on entry to ISSUE.
- `alu_a`, `alu_b` and `alu_op` hold their values after ISSUE until the next grant. The opcode is passed through unmodified.
- Requester protocol:
  - Operands must be stable from `req` rise until `ack`.
  - `req` must drop in the cycle after `ack`. If it is still high in IDLE, it counts as a new request.
  - A requester that drops `req` before being granted is simply not considered.
  - A granted requester that drops `req` during ISSUE or WAIT still receives its `ack`.
- Reset values: state=IDLE, `ack`=0, `rsp_y`=0, `rsp_err`=0, `busy`=0, `alu_start`=0, `alu_a`=0, `alu_b`=0, `alu_op`=0, `last`=NREQ-1 (requester 0 wins first), counter=0.
- `rst` in any state aborts the operation in progress with no `ack` and takes effect on the next edge.

## Timing
- Cycle 0: IDLE samples `req`.
- Cycle 1: ISSUE, `alu_start`=1.
- Cycle 2: WAIT sees `alu_done`=1, which `demo` registers one edge after `start`.
- Cycle 3: RESP, `ack` and `rsp_y` valid.
- Cycle 4: back in IDLE.
- Request-to-ack latency is 3 cycles. Peak throughput is one operation per 4 cycles.
- `busy` is high in cycles 1–3.
- Timeout path: `ack` arrives TIMEOUT+2 cycles after the request is sampled.

## Configuration
- `DEMO_ARB_RR_EN` defined: round-robin selection as described above.
- Not defined: fixed priority, where the lowest set `req` index always wins. The `last` register is removed and all other behaviour is identical.

## Test plan
- Single request: `req`=0001, A=0xF0F0_F0F0, B=0xFF00_FF00, op=0 (AND).
  - `alu_start` pulses in cycle 1.
  - In cycle 3: `ack`=0001, `rsp_y`=0xF000_F000, `rsp_err`=0.
- Fairness: `req`=1111 held continuously, with each requester re-raising `req` after its `ack`.
  - With RR: ack order is 0,1,2,3,0.
  - Without `DEMO_ARB_RR_EN`: every grant goes to 0.
- Back-to-back: requester 2 XOR A=0x1234_5678, B=0xFFFF_FFFF, then requester 1 OR A=0, B=0xA5A5_A5A5.
  - `rsp_y` = 0xEDCB_A987 in cycle 3, then 0xA5A5_A5A5 in cycle 7.
- Timeout: tie `alu_done`=0 with TIMEOUT=4 and request on requester 3.
  - `ack`=1000 with `rsp_err`=1 and `rsp_y`=0 in cycle 6.
- Reset mid-op: assert `rst` in the WAIT cycle.
  - Next cycle: state=IDLE, all outputs at reset values, no `ack`.
  - The next request then goes to requester 0.
- Early drop: requester 1 deasserts `req` in cycle 2 after being granted.
  - `ack`=0010 still fires in cycle 3.
  - No further `alu_start` follows.
